systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
Sequencer for a weight-stationary ROWS x COLS array of FMA PEs. Each PE computes a*b + c and registers the result, so there is 1 cycle per hop.
On start, the block loads one weight row per cycle, streams k_len activation vectors with per-row diagonal skew, then drains the partial-sum pipeline.
It generates the buffer read strobes, the per-row activation valids and the per-column result valids, and signals completion.
It sits between the top-level command interface and the PE array plus its weight/activation SRAMs. Both SRAMs have 1-cycle read latency.

Parameters:
ARRAY_ROWS, 4, number of PE rows; equals partial-sum pipeline depth and number of weight rows.
ARRAY_COLS, 4, number of PE columns.
ADDR_WIDTH, 10, activation/weight buffer address width.

Ports:
clk  input  1  clock; all logic is rising-edge.
reset  input  1  asynchronous, active-low reset; all state clears while low.
start  input  1  begin one job; sampled only in IDLE.
k_len  input  ADDR_WIDTH+1  number of activation vectors; latched when start is accepted.
busy  output  1  high in LOAD_W, STREAM and DRAIN.
done  output  1  one-cycle pulse at job end.
wgt_rd_en  output  1  weight buffer read strobe.
wgt_rd_addr  output  ADDR_WIDTH  weight row address.
wgt_load  output  1  array weight-shift enable; equals wgt_rd_en delayed 1 cycle.
act_rd_en  output  1  activation buffer read strobe.
act_rd_addr  output  ADDR_WIDTH  activation vector address.
row_en  output  ARRAY_ROWS  row_en[r] equals act_rd_en delayed 1+r cycles.
out_valid  output  ARRAY_COLS  out_valid[c] equals act_rd_en delayed 1+ARRAY_ROWS+c cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs go to 0, all delay lines clear, all counters clear, latched k_len clears.
  - This applies mid-job too: no partial outputs continue after reset is released.
- States and transitions:
  - IDLE: on start=1, latch k_len and go to LOAD_W.
  - LOAD_W: wgt_rd_en=1 for exactly ARRAY_ROWS cycles, wgt_rd_addr = 0..ARRAY_ROWS-1. Then go to STREAM, or to DRAIN if the latched k_len is 0.
  - STREAM: act_rd_en=1 for exactly k_len cycles, act_rd_addr = 0..k_len-1. Then go to DRAIN.
  - DRAIN: hold for exactly ARRAY_ROWS+ARRAY_COLS cycles. Then go to DONE.
  - DONE: done=1 and busy=0 for one cycle. Then go to IDLE.
- start is ignored in every state except IDLE. There is no queueing.
- The first STREAM cycle may coincide with the last wgt_load cycle. This is legal, because row_en[0] rises one cycle later.
- Addresses: counters reset to 0 at each phase entry and never wrap within a phase. Outside an active strobe, addresses hold their last value. They are don't-care.
- k_len saturation: k_len > 2**ADDR_WIDTH saturates to 2**ADDR_WIDTH. act_rd_addr then runs 0..2**ADDR_WIDTH-1.
- Delay lines: shift every cycle in all states, including DONE and IDLE. The DRAIN length guarantees all row_en and out_valid bits are 0 by DONE.
- Total job latency: done asserts 1 + ARRAY_ROWS + k_len + ARRAY_ROWS + ARRAY_COLS cycles after the cycle in which start is sampled. This uses the saturated k_len.

Test Plan:
- Nominal job (ROWS=COLS=4, k_len=3, start high in cycle 0):
  - wgt_rd_en in cycles 1-4 with addr 0-3; wgt_load in cycles 2-5.
  - act_rd_en in cycles 5-7 with addr 0-2.
  - row_en[0] in 6-8, row_en[3] in 9-11.
  - out_valid[0] in 10-12, out_valid[3] in 13-15.
  - busy in 1-15; done only in cycle 16.
- Zero-length job (k_len=0):
  - Weight phase as in the nominal job.
  - act_rd_en, row_en and out_valid never assert.
  - done in cycle 13.
- Start while busy: pulse start in cycles 3 and 10 of the nominal job -> no restart, identical waveform; a new start in cycle 17 -> second job with identical relative timing.
- Reset mid-job: reset=0 in cycle 8 of the nominal job -> all outputs 0 immediately. After release: IDLE, no done, and the next start behaves nominally.
- Saturation (ADDR_WIDTH=2, k_len=7): act_rd_en for exactly 4 cycles with addr 0,1,2,3, no wrap; done at 1+4+4+8 cycles after start.
- Back-to-back jobs (k_len=5, then k_len=1, second start in the IDLE cycle after done): each job's row_en and out_valid pulse counts equal its k_len; no overlap between jobs.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary ARRAY_ROWS x ARRAY_COLS FMA systolic array.
// A job has four phases: load the weight rows, stream k_len activation vectors,
// drain the partial-sum pipeline, then signal done for one cycle.
module systolic_array_ctrl #(
   parameter int unsigned ARRAY_ROWS = 4,
   parameter int unsigned ARRAY_COLS = 4,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   k_len,
   output logic                  busy,
   output logic                  done,
   output logic                  wgt_rd_en,
   output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
   output logic                  wgt_load,
   output logic                  act_rd_en,
   output logic [ADDR_WIDTH-1:0] act_rd_addr,
   output logic [ARRAY_ROWS-1:0] row_en,
   output logic [ARRAY_COLS-1:0] out_valid
);

   // One delay tap per cycle from the activation read to the last column output.
   localparam int unsigned DLY_LEN = ARRAY_ROWS + ARRAY_COLS;
   localparam int unsigned DRAIN_W = $clog2(DLY_LEN + 1);

   localparam logic [ADDR_WIDTH:0]   K_MAX      = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] WADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] WGT_LAST   = ADDR_WIDTH'(ARRAY_ROWS - 1);
   localparam logic [DRAIN_W-1:0]    DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};
   localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(DLY_LEN - 1);

   typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   k_q, k_d;
   logic [ADDR_WIDTH-1:0] wgt_addr_q, wgt_addr_d;
   logic [ADDR_WIDTH:0]   act_cnt_q, act_cnt_d;
   logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic [DLY_LEN-1:0]    dly_q, dly_d;
   logic                  wgt_load_q;

   // Next-state, counters and phase strobes.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      wgt_addr_d  = wgt_addr_q;
      act_cnt_d   = act_cnt_q;
      drain_cnt_d = drain_cnt_q;
      busy        = 1'b0;
      done        = 1'b0;
      wgt_rd_en   = 1'b0;
      act_rd_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               // Saturate so the stream phase never wraps the address space.
               k_d        = (k_len > K_MAX) ? K_MAX : k_len;
               wgt_addr_d = '0;
               state_d    = StLoadW;
            end
         end
         StLoadW: begin
            busy      = 1'b1;
            wgt_rd_en = 1'b1;
            if (wgt_addr_q == WGT_LAST) begin
               if (k_q == '0) begin
                  drain_cnt_d = '0;
                  state_d     = StDrain;
               end else begin
                  act_cnt_d = '0;
                  state_d   = StStream;
               end
            end else begin
               wgt_addr_d = wgt_addr_q + WADDR_ONE;
            end
         end
         StStream: begin
            busy      = 1'b1;
            act_rd_en = 1'b1;
            if ((act_cnt_q + CNT_ONE) == k_q) begin
               drain_cnt_d = '0;
               state_d     = StDrain;
            end else begin
               act_cnt_d = act_cnt_q + CNT_ONE;
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = StDone;
            end else begin
               drain_cnt_d = drain_cnt_q + DRAIN_ONE;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Tap i carries act_rd_en delayed by i+1 cycles.
      dly_d = {dly_q[DLY_LEN-2:0], act_rd_en};
   end

   // State, counters and delay lines; all clear asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         k_q         <= '0;
         wgt_addr_q  <= '0;
         act_cnt_q   <= '0;
         drain_cnt_q <= '0;
         dly_q       <= '0;
         wgt_load_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         wgt_addr_q  <= wgt_addr_d;
         act_cnt_q   <= act_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         dly_q       <= dly_d;
         wgt_load_q  <= wgt_rd_en;
      end
   end

   assign wgt_rd_addr = wgt_addr_q;
   assign wgt_load    = wgt_load_q;
   assign act_rd_addr = act_cnt_q[ADDR_WIDTH-1:0];
   assign row_en      = dly_q[ARRAY_ROWS-1:0];
   assign out_valid   = dly_q[DLY_LEN-1:ARRAY_ROWS];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: a default-size instance for the job
// scenarios and a 2-bit-address instance for k_len saturation.
module tb_systolic_array_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [10:0] k_len;
   logic       busy, done, wgt_rd_en, wgt_load, act_rd_en;
   logic [9:0] wgt_rd_addr, act_rd_addr;
   logic [3:0] row_en, out_valid;

   logic       start2;
   logic [2:0] k_len2;
   logic       busy2, done2, wgt_rd_en2, wgt_load2, act_rd_en2;
   logic [1:0] wgt_rd_addr2, act_rd_addr2;
   logic [3:0] row_en2, out_valid2;

   int total = 0;
   int bad   = 0;

   systolic_array_ctrl #(.ARRAY_ROWS(4), .ARRAY_COLS(4), .ADDR_WIDTH(10)) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .busy(busy), .done(done), .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
      .wgt_load(wgt_load), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
      .row_en(row_en), .out_valid(out_valid)
   );

   systolic_array_ctrl #(.ARRAY_ROWS(4), .ARRAY_COLS(4), .ADDR_WIDTH(2)) dut_sat (
      .clk(clk), .reset(reset), .start(start2), .k_len(k_len2),
      .busy(busy2), .done(done2), .wgt_rd_en(wgt_rd_en2), .wgt_rd_addr(wgt_rd_addr2),
      .wgt_load(wgt_load2), .act_rd_en(act_rd_en2), .act_rd_addr(act_rd_addr2),
      .row_en(row_en2), .out_valid(out_valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Outputs after reset, both while held and just after release.
   task automatic test_reset();
      reset  = 1'b0;
      start  = 1'b0;
      k_len  = '0;
      start2 = 1'b0;
      k_len2 = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, wgt_rd_en, wgt_load, act_rd_en, row_en, out_valid} !== 13'd0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=0",
                  {busy, done, wgt_rd_en, wgt_load, act_rd_en, row_en, out_valid});
      end
      total++;
      if ({wgt_rd_addr, act_rd_addr} !== 20'd0) begin
         bad++;
         $display("FAIL reset_addr got=%h want=0", {wgt_rd_addr, act_rd_addr});
      end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done, busy2, done2} !== 4'd0) begin
         bad++;
         $display("FAIL reset_release got=%b want=0", {busy, done, busy2, done2});
      end
   endtask

   // Nominal k_len=3 job starting now; extra start pulses at s1/s2 must be ignored.
   // Covers cycles 0..16 relative to the start cycle.
   task automatic run_nominal(input string tag, input int s1, input int s2);
      logic [3:0] exp_row, exp_ov;
      logic [9:0] exp_a;
      for (int t = 0; t <= 16; t++) begin
         start = (t == 0) || (t == s1) || (t == s2);
         k_len = 11'd3;
         for (int r = 0; r < 4; r++) begin
            exp_row[r] = (t >= 6 + r) && (t <= 8 + r);
            exp_ov[r]  = (t >= 10 + r) && (t <= 12 + r);
         end
         total++;
         if (busy !== ((t >= 1) && (t <= 15))) begin
            bad++; $display("FAIL %s_busy t=%0d got=%b", tag, t, busy);
         end
         total++;
         if (done !== (t == 16)) begin
            bad++; $display("FAIL %s_done t=%0d got=%b", tag, t, done);
         end
         total++;
         if (wgt_rd_en !== ((t >= 1) && (t <= 4))) begin
            bad++; $display("FAIL %s_wgt_rd_en t=%0d got=%b", tag, t, wgt_rd_en);
         end
         total++;
         if (wgt_load !== ((t >= 2) && (t <= 5))) begin
            bad++; $display("FAIL %s_wgt_load t=%0d got=%b", tag, t, wgt_load);
         end
         total++;
         if (act_rd_en !== ((t >= 5) && (t <= 7))) begin
            bad++; $display("FAIL %s_act_rd_en t=%0d got=%b", tag, t, act_rd_en);
         end
         if ((t >= 1) && (t <= 4)) begin
            exp_a = 10'(t - 1);
            total++;
            if (wgt_rd_addr !== exp_a) begin
               bad++;
               $display("FAIL %s_wgt_addr t=%0d got=%0d want=%0d", tag, t, wgt_rd_addr, exp_a);
            end
         end
         if ((t >= 5) && (t <= 7)) begin
            exp_a = 10'(t - 5);
            total++;
            if (act_rd_addr !== exp_a) begin
               bad++;
               $display("FAIL %s_act_addr t=%0d got=%0d want=%0d", tag, t, act_rd_addr, exp_a);
            end
         end
         total++;
         if (row_en !== exp_row) begin
            bad++; $display("FAIL %s_row_en t=%0d got=%b want=%b", tag, t, row_en, exp_row);
         end
         total++;
         if (out_valid !== exp_ov) begin
            bad++; $display("FAIL %s_out_valid t=%0d got=%b want=%b", tag, t, out_valid, exp_ov);
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_nominal();
      run_nominal("nominal", -1, -1);
   endtask

   // k_len=0: weight phase only, then drain; done at cycle 13.
   task automatic test_zero_len();
      for (int t = 0; t <= 15; t++) begin
         start = (t == 0);
         k_len = 11'd0;
         total++;
         if (wgt_rd_en !== ((t >= 1) && (t <= 4))) begin
            bad++; $display("FAIL zero_wgt_rd_en t=%0d got=%b", t, wgt_rd_en);
         end
         total++;
         if ({act_rd_en, row_en, out_valid} !== 9'd0) begin
            bad++; $display("FAIL zero_act t=%0d got=%b want=0", t, {act_rd_en, row_en, out_valid});
         end
         total++;
         if (done !== (t == 13)) begin
            bad++; $display("FAIL zero_done t=%0d got=%b", t, done);
         end
         total++;
         if (busy !== ((t >= 1) && (t <= 12))) begin
            bad++; $display("FAIL zero_busy t=%0d got=%b", t, busy);
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   // Starts during a job are ignored; a start right after done runs a fresh job.
   task automatic test_start_while_busy();
      run_nominal("busy_first", 3, 10);
      run_nominal("busy_second", -1, -1);
   endtask

   // Reset asserted mid-job clears outputs at once and leaves the block idle.
   task automatic test_reset_mid_job();
      for (int t = 0; t < 8; t++) begin
         start = (t == 0);
         k_len = 11'd3;
         @(negedge clk);
      end
      start = 1'b0;
      reset = 1'b0;
      #1;
      total++;
      if ({busy, done, wgt_rd_en, wgt_load, act_rd_en, row_en, out_valid} !== 13'd0) begin
         bad++;
         $display("FAIL midreset_outputs got=%b want=0",
                  {busy, done, wgt_rd_en, wgt_load, act_rd_en, row_en, out_valid});
      end
      @(negedge clk);
      reset = 1'b1;
      for (int t = 0; t < 12; t++) begin
         total++;
         if ({busy, done, act_rd_en, row_en, out_valid} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_idle t=%0d got=%b want=0", t,
                     {busy, done, act_rd_en, row_en, out_valid});
         end
         @(negedge clk);
      end
      run_nominal("after_reset", -1, -1);
   endtask

   // ADDR_WIDTH=2 instance, k_len=7 saturates to 4: addr 0..3, done at 17.
   task automatic test_saturation();
      int         acts;
      logic [1:0] exp_a;
      acts = 0;
      for (int t = 0; t <= 20; t++) begin
         start2 = (t == 0);
         k_len2 = 3'd7;
         total++;
         if (act_rd_en2 !== ((t >= 5) && (t <= 8))) begin
            bad++; $display("FAIL sat_act_rd_en t=%0d got=%b", t, act_rd_en2);
         end
         if (act_rd_en2 === 1'b1) begin
            acts++;
            exp_a = 2'(t - 5);
            total++;
            if (act_rd_addr2 !== exp_a) begin
               bad++;
               $display("FAIL sat_act_addr t=%0d got=%0d want=%0d", t, act_rd_addr2, exp_a);
            end
         end
         total++;
         if (done2 !== (t == 17)) begin
            bad++; $display("FAIL sat_done t=%0d got=%b", t, done2);
         end
         @(negedge clk);
      end
      start2 = 1'b0;
      total++;
      if (acts !== 4) begin
         bad++; $display("FAIL sat_act_count got=%0d want=4", acts);
      end
   endtask

   // k_len=5 then k_len=1, second start in the idle cycle after done.
   task automatic test_back_to_back();
      int row1[4], row2[4], ov1[4], ov2[4];
      for (int i = 0; i < 4; i++) begin
         row1[i] = 0; row2[i] = 0; ov1[i] = 0; ov2[i] = 0;
      end
      for (int t = 0; t <= 36; t++) begin
         start = (t == 0) || (t == 19);
         k_len = (t < 19) ? 11'd5 : 11'd1;
         total++;
         if (done !== ((t == 18) || (t == 33))) begin
            bad++; $display("FAIL b2b_done t=%0d got=%b", t, done);
         end
         total++;
         if (busy !== (((t >= 1) && (t <= 17)) || ((t >= 20) && (t <= 32)))) begin
            bad++; $display("FAIL b2b_busy t=%0d got=%b", t, busy);
         end
         for (int i = 0; i < 4; i++) begin
            if (t <= 18) begin
               row1[i] += int'(row_en[i]);
               ov1[i]  += int'(out_valid[i]);
            end else begin
               row2[i] += int'(row_en[i]);
               ov2[i]  += int'(out_valid[i]);
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ((row1[i] !== 5) || (ov1[i] !== 5)) begin
            bad++;
            $display("FAIL b2b_job1_counts bit=%0d got row=%0d ov=%0d want=5", i, row1[i], ov1[i]);
         end
         total++;
         if ((row2[i] !== 1) || (ov2[i] !== 1)) begin
            bad++;
            $display("FAIL b2b_job2_counts bit=%0d got row=%0d ov=%0d want=1", i, row2[i], ov2[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_zero_len();
      test_start_while_busy();
      test_reset_mid_job();
      test_saturation();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
